// File: rtl/fwd_hazard_scoreboard.sv
// Operand-forwarding scoreboard beside EX: tracks destination tags of retired-from-EX
// instructions, picks forwarding sources, raises load-use stalls and late store-data forwarding.
module fwd_hazard_scoreboard #(
  parameter int AW         = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SELW       = $clog2(FWD_DEPTH + 1),
  parameter int CNTW       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    advance,
  input  logic                    flush,
  input  logic                    ex_valid,
  input  logic [AW-1:0]           ex_rd,
  input  logic                    ex_regwrite,
  input  logic                    ex_is_load,
  input  logic                    ex_is_store,
  input  logic [NUM_SRC*AW-1:0]   ex_src,
  input  logic [NUM_SRC-1:0]      ex_src_used,
  output logic [NUM_SRC*SELW-1:0] fwd_sel,
  output logic                    store_late_fwd,
  output logic                    stall,
  output logic [CNTW-1:0]         stall_count
);

  // Source index carrying store data; only meaningful when a second source exists.
  localparam int DATA_SRC = (NUM_SRC > 1) ? 1 : 0;
  localparam bit HAS_DATA = (NUM_SRC > 1);

  logic [FWD_DEPTH:1] v_q, wr_q, ld_q;
  logic [AW-1:0]      rd_q [1:FWD_DEPTH];
  logic [FWD_DEPTH:1] m [NUM_SRC];
  logic               store_dep;

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        m[s][k] = ex_valid && ex_src_used[s] && v_q[k] && wr_q[k] &&
                  (rd_q[k] == ex_src[s*AW +: AW]) && (rd_q[k] != '0);
      end
    end
  end

  assign store_dep = HAS_DATA && ex_is_store && m[DATA_SRC][1];

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    stall          = 1'b0;
    store_late_fwd = 1'b0;
    fwd_sel        = '0;

    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        // A stage-1 load feeding store data is picked up at MEM, so it need not stall.
        if (m[s][k] && ld_q[k] && (k < LOAD_STAGE) &&
            !(s == DATA_SRC && store_dep && k == 1 && LOAD_STAGE <= 2)) begin
          stall = 1'b1;
        end
      end
    end

    // Walk oldest to youngest so the youngest matching stage is the one left standing.
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (m[s][k] && !(s == DATA_SRC && store_dep && k == 1)) begin
          fwd_sel[s*SELW +: SELW] = SELW'(k);
        end
      end
    end

    if (stall) begin
      fwd_sel = '0;
    end else begin
      store_late_fwd = store_dep;
    end
  end

  // NOTE: state uses non-blocking assignments so every stage samples its predecessor's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= '0;
      wr_q        <= '0;
      ld_q        <= '0;
      stall_count <= '0;
      // NOTE: the tag array is small flop storage, so it is cleared too; it is not a RAM.
      for (int k = 1; k <= FWD_DEPTH; k++) rd_q[k] <= '0;
    end else if (advance) begin
      for (int k = FWD_DEPTH; k >= 2; k--) begin
        v_q[k]  <= v_q[k-1];
        wr_q[k] <= wr_q[k-1];
        ld_q[k] <= ld_q[k-1];
        rd_q[k] <= rd_q[k-1];
      end
      v_q[1]  <= ex_valid && !flush && !stall;
      wr_q[1] <= ex_regwrite;
      ld_q[1] <= ex_is_load;
      rd_q[1] <= ex_rd;
      if (stall && (stall_count != {CNTW{1'b1}})) begin
        stall_count <= stall_count + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard: expected outputs are queued with each step
// and compared once the combinational outputs settle.
module tb_fwd_hazard_scoreboard;

  localparam int AW = 5, NUM_SRC = 2, SELW = 2, CNTW = 16, SAT_W = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    advance, flush, ex_valid, ex_regwrite, ex_is_load, ex_is_store;
  logic [AW-1:0]           ex_rd;
  logic [NUM_SRC*AW-1:0]   ex_src;
  logic [NUM_SRC-1:0]      ex_src_used;
  logic [NUM_SRC*SELW-1:0] fwd_sel, sat_fwd_sel;
  logic                    store_late_fwd, stall, sat_late, sat_stall;
  logic [CNTW-1:0]         stall_count;
  logic [SAT_W-1:0]        sat_count;

  typedef struct {
    string           tag;
    logic [3:0]      sel;
    logic            late;
    logic            stl;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_src(ex_src), .ex_src_used(ex_src_used),
    .fwd_sel(fwd_sel), .store_late_fwd(store_late_fwd),
    .stall(stall), .stall_count(stall_count)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  fwd_hazard_scoreboard #(.CNTW(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_src(ex_src), .ex_src_used(ex_src_used),
    .fwd_sel(sat_fwd_sel), .store_late_fwd(sat_late),
    .stall(sat_stall), .stall_count(sat_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      check({e.tag, ".fwd_sel"}, 32'(fwd_sel), 32'(e.sel));
      check({e.tag, ".late"},    32'(store_late_fwd), 32'(e.late));
      check({e.tag, ".stall"},   32'(stall), 32'(e.stl));
      check({e.tag, ".count"},   32'(stall_count), 32'(e.cnt));
    end
  endtask

  // One directed step: drive EX after the falling edge, queue the expectation, compare, then
  // let the next rising edge commit state.
  task automatic step(input string tag,
                      input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                      input logic st, input logic [4:0] s0, input logic [4:0] s1,
                      input logic [1:0] used, input logic adv, input logic fl,
                      input logic [3:0] e_sel, input logic e_late, input logic e_stall,
                      input logic [CNTW-1:0] e_cnt);
    exp_t e;
    @(negedge clk);
    ex_valid = v; ex_rd = rd; ex_regwrite = wr; ex_is_load = ld; ex_is_store = st;
    ex_src = {s1, s0}; ex_src_used = used; advance = adv; flush = fl;
    e.tag = tag; e.sel = e_sel; e.late = e_late; e.stl = e_stall; e.cnt = e_cnt;
    exp_q.push_back(e);
    #1;
    compare();
  endtask

  initial begin
    rst_n = 1'b0;
    advance = 0; flush = 0; ex_valid = 0; ex_rd = '0; ex_regwrite = 0;
    ex_is_load = 0; ex_is_store = 0; ex_src = '0; ex_src_used = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('{tag: "reset", sel: 4'h0, late: 1'b0, stl: 1'b0, cnt: '0});
    compare();
    @(negedge clk);
    rst_n = 1'b1;

    //    tag         v rd  wr ld st s0  s1  used adv fl  sel   late stl cnt
    // Back-to-back ALU dependence, then one instruction apart.
    step("add_r3",    1, 3, 1, 0, 0, 0,  0,  2'b00, 1, 0, 4'h0, 0, 0, 0);
    step("sub_r3_r5", 1, 8, 1, 0, 0, 3,  5,  2'b11, 1, 0, 4'h1, 0, 0, 0);
    step("gap_r3",    1, 9, 1, 0, 0, 3,  0,  2'b01, 1, 0, 4'h2, 0, 0, 0);
    // Load-use: one stall cycle with a bubble, then forward from stage 2.
    step("lw_r1",     1, 1, 1, 1, 0, 0,  0,  2'b00, 1, 0, 4'h0, 0, 0, 0);
    step("use_stall", 1, 2, 1, 1, 0, 1,  0,  2'b01, 1, 0, 4'h0, 0, 1, 0);
    step("use_fwd2",  1, 2, 1, 1, 0, 1,  0,  2'b01, 1, 0, 4'h2, 0, 0, 1);
    // Youngest writer wins.
    step("w_r6_a",    1, 6, 1, 0, 0, 0,  0,  2'b00, 1, 0, 4'h0, 0, 0, 1);
    step("w_r6_b",    1, 6, 1, 0, 0, 0,  0,  2'b00, 1, 0, 4'h0, 0, 0, 1);
    step("youngest",  1, 10, 1, 0, 0, 0, 6,  2'b10, 1, 0, 4'h4, 0, 0, 1);
    // Register zero never forwards.
    step("w_r0",      1, 0, 1, 0, 0, 0,  0,  2'b00, 1, 0, 4'h0, 0, 0, 1);
    step("read_r0",   1, 7, 1, 0, 0, 0,  0,  2'b11, 1, 0, 4'h0, 0, 0, 1);
    // Store data from stage 1 goes late; with stage 2 also writing r7 it falls to stage 2.
    step("sw_late",   1, 0, 0, 0, 1, 0,  7,  2'b11, 1, 0, 4'h0, 1, 0, 1);
    step("w_r7_a",    1, 7, 1, 0, 0, 0,  0,  2'b00, 1, 0, 4'h0, 0, 0, 1);
    step("w_r7_b",    1, 7, 1, 0, 0, 0,  0,  2'b00, 1, 0, 4'h0, 0, 0, 1);
    step("sw_fall2",  1, 0, 0, 0, 1, 0,  7,  2'b10, 0, 0, 4'h8, 1, 0, 1);
    // Store data depending on a stage-1 load: no stall, late forward.
    step("lw_r11",    1, 11, 1, 1, 0, 0, 0,  2'b00, 1, 0, 4'h0, 0, 0, 1);
    step("sw_ld",     1, 0, 0, 0, 1, 0,  11, 2'b10, 0, 0, 4'h0, 1, 0, 1);
    // Source 0 of a store on a stage-1 load still stalls.
    step("sw_base_ld",1, 0, 0, 0, 1, 11, 0,  2'b01, 0, 0, 4'h0, 0, 1, 1);
    // Flushed instruction leaves a bubble.
    step("flush_r4",  1, 4, 1, 0, 0, 0,  0,  2'b00, 1, 1, 4'h0, 0, 0, 1);
    step("read_r4",   1, 12, 1, 0, 0, 4, 0,  2'b01, 1, 0, 4'h0, 0, 0, 1);
    // Asynchronous reset releases a pending stall without a clock edge.
    step("lw_r13",    1, 13, 1, 1, 0, 0, 0,  2'b00, 1, 0, 4'h0, 0, 0, 1);
    step("hold_stall",1, 14, 1, 0, 0, 13, 0, 2'b01, 0, 0, 4'h0, 0, 1, 1);
    #1;
    rst_n = 1'b0;
    exp_q.push_back('{tag: "async_rst", sel: 4'h0, late: 1'b0, stl: 1'b0, cnt: '0});
    #1;
    compare();
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation: each stall+advance needs a fresh stage-1 load, so alternate load and reader.
    for (int i = 0; i < (1 << SAT_W) + 3; i++) begin
      step("sat_lw",  1, 14, 1, 1, 0, 0,  0,  2'b00, 1, 0, 4'h0, 0, 0, CNTW'(i));
      step("sat_use", 1, 15, 1, 0, 0, 14, 0,  2'b01, 1, 0, 4'h0, 0, 1, CNTW'(i));
    end
    step("sat_done",  0, 0, 0, 0, 0, 0,  0,  2'b00, 0, 0, 4'h0, 0, 0, CNTW'((1 << SAT_W) + 3));
    check("sat_count", 32'(sat_count), 32'((1 << SAT_W) - 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
